split_scheduler: RTL and testbench

SPLIT_SCHEDULER -- requirements
Module: split_scheduler

---
 rtl/split_sched_pkg.sv | 16 +
 rtl/split_scheduler_if.sv | 27 ++
 rtl/split_timer.sv | 25 ++
 rtl/split_scheduler.sv | 138 +++++++++++++
 tb/tb_split_scheduler.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/split_sched_pkg.sv
// Shared types for the split-transaction bus scheduler: FSM state encoding and
// the bit positions of each master inside the parked mask.
package split_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StOwn,
        StOwnParked,
        StIdleParked,
        StResume
    } sched_state_t;

    localparam int unsigned ParkM1Bit = 0;
    localparam int unsigned ParkM2Bit = 1;

endpackage

// File: rtl/split_scheduler_if.sv
// Request/grant and split-control signals between two bus masters, the split-capable
// slave and the scheduler. The scheduler sits on the slave modport.
interface split_scheduler_if;

    logic       m1_req;
    logic       m2_req;
    logic       m1_done;
    logic       m2_done;
    logic       slv_split;
    logic       slv_resume;
    logic       m1_grant;
    logic       m2_grant;
    logic [1:0] parked;
    logic       split_abort;
    logic       bus_busy;

    modport master (
        output m1_req, m2_req, m1_done, m2_done, slv_split, slv_resume,
        input  m1_grant, m2_grant, parked, split_abort, bus_busy
    );

    modport slave (
        input  m1_req, m2_req, m1_done, m2_done, slv_split, slv_resume,
        output m1_grant, m2_grant, parked, split_abort, bus_busy
    );

endinterface

// File: rtl/split_timer.sv
// Saturating wait counter for a parked master; expire pulses on the cycle the
// count is about to reach Limit.
module split_timer #(
    parameter logic [7:0] Limit = 8'd200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= 8'd0;
        end else if (enable && (count_q != Limit)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expire = enable && !clear && (count_q == Limit - 8'd1);

endmodule

// File: rtl/split_scheduler.sv
// Two-master bus scheduler with split/park, deferred resume and parked-master timeout.
// Define SPLIT_SCHED_RR_EN for round-robin tie-breaking; default is fixed m1 priority.
module split_scheduler
    import split_sched_pkg::*;
#(
    parameter logic [7:0] SPLIT_TMO = 8'd200
) (
    input logic              clk,
    input logic              rst,
    split_scheduler_if.slave bus
);

    sched_state_t state_q;
    logic         m1_grant_q, m2_grant_q, abort_q, pending_q;
    logic [1:0]   parked_q;
    logic         owner_done, m1_elig, m2_elig, pick_m1, pick_m2;
    logic         split_take, resume_take, timer_en, tmo_expire, abort_now;

    assign owner_done = (m1_grant_q && bus.m1_done) || (m2_grant_q && bus.m2_done);
    assign m1_elig    = bus.m1_req && !parked_q[ParkM1Bit];
    assign m2_elig    = bus.m2_req && !parked_q[ParkM2Bit];

`ifdef SPLIT_SCHED_RR_EN
    logic last_m2_q;  // last_served: set means m2 was served last, so m1 wins the next tie

    always_ff @(posedge clk) begin
        if (rst) begin
            last_m2_q <= 1'b1;
        end else if (m1_grant_q) begin
            last_m2_q <= 1'b0;
        end else if (m2_grant_q) begin
            last_m2_q <= 1'b1;
        end
    end

    assign pick_m1 = m1_elig && (!m2_elig || last_m2_q);
`else
    assign pick_m1 = m1_elig;
`endif
    assign pick_m2 = m2_elig && !pick_m1;

    assign split_take  = (state_q == StOwn) && bus.slv_split && !owner_done;
    assign resume_take = bus.slv_resume && ((state_q == StIdleParked) || (state_q == StOwnParked));
    // The resumed master is already chosen in RESUME, so it can no longer time out.
    assign timer_en    = (parked_q != 2'b00) && (state_q != StResume);
    assign abort_now   = tmo_expire && !resume_take;

    split_timer #(
        .Limit(SPLIT_TMO)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (split_take),
        .enable(timer_en),
        .expire(tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            m1_grant_q <= 1'b0;
            m2_grant_q <= 1'b0;
            parked_q   <= 2'b00;
            abort_q    <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            abort_q <= abort_now;
            if (abort_now) begin
                parked_q  <= 2'b00;
                pending_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    m1_grant_q <= pick_m1;
                    m2_grant_q <= pick_m2;
                    if (pick_m1 || pick_m2) state_q <= StOwn;
                end
                StOwn: begin
                    if (owner_done) begin
                        m1_grant_q <= 1'b0;
                        m2_grant_q <= 1'b0;
                        state_q    <= StIdle;
                    end else if (split_take) begin
                        m1_grant_q          <= 1'b0;
                        m2_grant_q          <= 1'b0;
                        parked_q[ParkM1Bit] <= m1_grant_q;
                        parked_q[ParkM2Bit] <= m2_grant_q;
                        state_q             <= StIdleParked;
                    end
                end
                StIdleParked: begin
                    if (resume_take) begin
                        state_q <= StResume;
                    end else begin
                        m1_grant_q <= pick_m1;
                        m2_grant_q <= pick_m2;
                        if (pick_m1 || pick_m2) begin
                            state_q <= abort_now ? StOwn : StOwnParked;
                        end else if (abort_now) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StOwnParked: begin
                    if (resume_take) pending_q <= 1'b1;
                    if (owner_done) begin
                        m1_grant_q <= 1'b0;
                        m2_grant_q <= 1'b0;
                        if (abort_now) begin
                            state_q <= StIdle;
                        end else if (pending_q || resume_take) begin
                            state_q <= StResume;
                        end else begin
                            state_q <= StIdleParked;
                        end
                    end else if (abort_now) begin
                        state_q <= StOwn;
                    end
                end
                StResume: begin
                    m1_grant_q <= parked_q[ParkM1Bit];
                    m2_grant_q <= parked_q[ParkM2Bit];
                    parked_q   <= 2'b00;
                    pending_q  <= 1'b0;
                    state_q    <= StOwn;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.m1_grant    = m1_grant_q;
    assign bus.m2_grant    = m2_grant_q;
    assign bus.parked      = parked_q;
    assign bus.split_abort = abort_q;
    assign bus.bus_busy    = m1_grant_q || m2_grant_q;

endmodule

// File: tb/tb_split_scheduler.sv
// Directed bench for split_scheduler: a vector table for arbitration/reset plus
// cycle-indexed sequences for split/resume and timeout behaviour.
module tb_split_scheduler;

    localparam logic [6:0] InRst = 7'b1000000;
    localparam logic [6:0] InR1  = 7'b0100000;
    localparam logic [6:0] InR2  = 7'b0010000;
    localparam logic [6:0] InD1  = 7'b0001000;
    localparam logic [6:0] InD2  = 7'b0000100;
    localparam logic [6:0] InSp  = 7'b0000010;
    localparam logic [6:0] InRs  = 7'b0000001;
    localparam logic [6:0] InNo  = 7'b0000000;

    // exp bits: {m1_grant, m2_grant, parked[1], parked[0], split_abort, bus_busy}
    typedef struct {
        logic [6:0] in;
        logic [5:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    split_scheduler_if bus ();
    split_scheduler_if bus_t ();

    split_scheduler dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    split_scheduler #(
        .SPLIT_TMO(8'd10)
    ) dut_tmo (
        .clk(clk),
        .rst(rst),
        .bus(bus_t)
    );

    function automatic logic [5:0] outs(input bit tmo);
        if (tmo) begin
            return {bus_t.m1_grant, bus_t.m2_grant, bus_t.parked, bus_t.split_abort,
                    bus_t.bus_busy};
        end
        return {bus.m1_grant, bus.m2_grant, bus.parked, bus.split_abort, bus.bus_busy};
    endfunction

    function automatic void add(input logic [6:0] in, input logic [5:0] exp, input string name);
        vecs.push_back('{in, exp, name});
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    task automatic drive(input logic [6:0] in);
        rst            = in[6];
        bus.m1_req     = in[5];
        bus.m2_req     = in[4];
        bus.m1_done    = in[3];
        bus.m2_done    = in[2];
        bus.slv_split  = in[1];
        bus.slv_resume = in[0];
        bus_t.m1_req     = in[5];
        bus_t.m2_req     = in[4];
        bus_t.m1_done    = in[3];
        bus_t.m2_done    = in[2];
        bus_t.slv_split  = in[1];
        bus_t.slv_resume = in[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("mutex", {5'b0, bus.m1_grant & bus.m2_grant}, 6'b0);
        check("mutex_tmo", {5'b0, bus_t.m1_grant & bus_t.m2_grant}, 6'b0);
    endtask

    task automatic do_reset();
        drive(InRst);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] in;
        logic [5:0] ex;

        // Reset state, then m1 request from cycle 3 with done at cycle 10.
        add(InRst, 6'b000000, "reset");
        for (int k = 0; k < 3; k++) add(InNo, 6'b000000, "idle");
        for (int k = 3; k < 10; k++) add(InR1, 6'b100001, "m1_own");
        add(InR1 | InD1, 6'b000000, "m1_done");
        add(InNo, 6'b000000, "idle_after");
        // Simultaneous requests after reset; second round shows the tie-break policy.
        add(InRst, 6'b000000, "reset2");
        for (int k = 0; k < 3; k++) add(InNo, 6'b000000, "idle2");
        add(InR1 | InR2, 6'b100001, "tie_first");
        add(InR1 | InR2 | InD1, 6'b000000, "tie_turn");
`ifdef SPLIT_SCHED_RR_EN
        add(InR1 | InR2, 6'b010001, "tie_second_rr");
`else
        add(InR1 | InR2, 6'b100001, "tie_second_fixed");
`endif
        add(InR1 | InR2 | InD1 | InD2, 6'b000000, "tie_done2");
        add(InR2, 6'b010001, "m2_own");
        add(InR2 | InD1, 6'b010001, "nonowner_done");
        add(InR2 | InD2, 6'b000000, "m2_done");
        add(InSp | InRs, 6'b000000, "split_idle_ignored");
        add(InNo, 6'b000000, "idle3");
        // Reset while OWN_PARKED, then a fresh m2 request.
        add(InRst, 6'b000000, "reset3");
        add(InR1 | InR2, 6'b100001, "own_m1");
        add(InR1 | InR2 | InSp, 6'b000100, "split_m1");
        add(InR1 | InR2, 6'b010101, "own_parked");
        add(InR1 | InR2 | InRst, 6'b000000, "reset_parked");
        add(InR2, 6'b010001, "m2_after_reset");
        add(InR2 | InD2, 6'b000000, "m2_done_after_reset");

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            step();
            check($sformatf("%s[%0d]", vecs[i].name, i), outs(1'b0), vecs[i].exp);
            check($sformatf("%s_tmo[%0d]", vecs[i].name, i), outs(1'b1), vecs[i].exp);
        end

        // Split at 8, second split at 15 ignored, resume at 20 while m2 owns, m2_done at 25.
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            ex = {(c >= 4 && c <= 8) || (c >= 27 && c <= 28), c >= 10 && c <= 25, 1'b0,
                  c >= 9 && c <= 26, 1'b0, 1'b0};
            ex[0] = ex[5] | ex[4];
            check($sformatf("split_resume c%0d", c), outs(1'b0), ex);
            in    = InNo;
            in[5] = (c >= 3 && c <= 28);
            in[4] = (c >= 3 && c <= 25);
            in[3] = (c == 28);
            in[2] = (c == 25);
            in[1] = (c == 8 || c == 15);
            in[0] = (c == 20);
            drive(in);
            step();
        end

        // Timeout of 10: parked from cycle 2, one abort pulse at cycle 12.
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            if (c == 1) ex = 6'b100001;
            else if (c >= 2 && c <= 11) ex = 6'b000100;
            else if (c == 12) ex = 6'b000010;
            else ex = 6'b000000;
            check($sformatf("timeout c%0d", c), outs(1'b1), ex);
            in    = InNo;
            in[5] = (c <= 1);
            in[1] = (c == 1);
            drive(in);
            step();
        end

        // Resume in the same cycle the timeout would fire: no abort, m1 re-granted.
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            if (c == 1 || c == 13) ex = 6'b100001;
            else if (c >= 2 && c <= 12) ex = 6'b000100;
            else ex = 6'b000000;
            check($sformatf("resume_race c%0d", c), outs(1'b1), ex);
            in    = InNo;
            in[5] = (c <= 13);
            in[3] = (c == 13);
            in[1] = (c == 1);
            in[0] = (c == 11);
            drive(in);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
